register_file: RTL

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/rf_pkg.sv | 11 +
 rtl/register_file_if.sv | 34 +++
 rtl/rf_storage.sv | 52 +++++
 rtl/register_file.sv | 75 +++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants for the register file: default geometry and the zero word
// returned for hardwired-zero and out-of-range reads.
package rf_pkg;

  localparam int RF_WIDTH  = 32;
  localparam int RF_DEPTH  = 32;
  localparam int RF_ADDR_W = 5;

  localparam logic [RF_WIDTH-1:0] RF_ZERO_WORD = '0;

endpackage

// File: rtl/register_file_if.sv
// Register file bus: one write port and two independent registered read ports.
// The master issues writes and read requests; the slave returns read data.
interface register_file_if
  import rf_pkg::*;
#(
  parameter int WIDTH  = RF_WIDTH,
  parameter int ADDR_W = RF_ADDR_W
);

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic              re_a;
  logic              re_b;
  logic [ADDR_W-1:0] raddr_a;
  logic [ADDR_W-1:0] raddr_b;
  logic [WIDTH-1:0]  rdata_a;
  logic [WIDTH-1:0]  rdata_b;
  logic [WIDTH-1:0]  rdata_a_comp;
  logic [WIDTH-1:0]  rdata_b_comp;
  logic              valid_a;
  logic              valid_b;

  modport master (
    output we, waddr, wdata, re_a, re_b, raddr_a, raddr_b,
    input  rdata_a, rdata_b, rdata_a_comp, rdata_b_comp, valid_a, valid_b
  );

  modport slave (
    input  we, waddr, wdata, re_a, re_b, raddr_a, raddr_b,
    output rdata_a, rdata_b, rdata_a_comp, rdata_b_comp, valid_a, valid_b
  );

endinterface

// File: rtl/rf_storage.sv
// Storage array with write decode and two combinational read muxes.
// Entry 0 stays zero when ZERO_REG=1; out-of-range addresses read as zero.
module rf_storage
  import rf_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rd_a,
  output logic [WIDTH-1:0]  rd_b
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_ok;

  assign wr_ok = we && (int'(waddr) < DEPTH) && !(ZERO_REG != 0 && waddr == '0);

  // NOTE: every entry is cleared on reset, so this maps to flops rather than
  // a RAM macro; the clear-on-reset behaviour is part of the contract.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!rst_n) begin
        mem[i] <= '0;
      end else if (wr_ok && waddr == ADDR_W'(i)) begin
        mem[i] <= wdata;
      end
    end
  end

  // NOTE: combinational logic uses blocking assignments with a default first,
  // so no path can leave rd_a/rd_b unassigned and infer a latch.
  always_comb begin
    rd_a = WIDTH'(RF_ZERO_WORD);
    rd_b = WIDTH'(RF_ZERO_WORD);
    for (int i = 0; i < DEPTH; i++) begin
      if (!(ZERO_REG != 0 && i == 0)) begin
        if (raddr_a == ADDR_W'(i)) rd_a = mem[i];
        if (raddr_b == ADDR_W'(i)) rd_b = mem[i];
      end
    end
  end

endmodule

// File: rtl/register_file.sv
// Two-read, one-write register file with 1-cycle registered reads.
// Define REGFILE_BYPASS_EN for write-through forwarding of same-cycle writes.
module register_file
  import rf_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  register_file_if.slave bus
);

  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  logic [WIDTH-1:0] fwd_a;
  logic [WIDTH-1:0] fwd_b;
  logic [WIDTH-1:0] rdata_a_q;
  logic [WIDTH-1:0] rdata_b_q;
  logic             valid_a_q;
  logic             valid_b_q;

  rf_storage #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_storage (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (bus.we),
    .waddr   (bus.waddr),
    .wdata   (bus.wdata),
    .raddr_a (bus.raddr_a),
    .raddr_b (bus.raddr_b),
    .rd_a    (rd_a),
    .rd_b    (rd_b)
  );

`ifdef REGFILE_BYPASS_EN
  // Forward only writes that storage would actually accept.
  logic wr_acc;
  assign wr_acc = bus.we && (int'(bus.waddr) < DEPTH) &&
                  !(ZERO_REG != 0 && bus.waddr == '0);
  assign fwd_a  = (wr_acc && bus.waddr == bus.raddr_a) ? bus.wdata : rd_a;
  assign fwd_b  = (wr_acc && bus.waddr == bus.raddr_b) ? bus.wdata : rd_b;
`else
  assign fwd_a = rd_a;
  assign fwd_b = rd_b;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_a_q <= '0;
      rdata_b_q <= '0;
      valid_a_q <= 1'b0;
      valid_b_q <= 1'b0;
    end else begin
      valid_a_q <= bus.re_a;
      valid_b_q <= bus.re_b;
      if (bus.re_a) rdata_a_q <= fwd_a;
      if (bus.re_b) rdata_b_q <= fwd_b;
    end
  end

  assign bus.rdata_a      = rdata_a_q;
  assign bus.rdata_b      = rdata_b_q;
  assign bus.rdata_a_comp = ~rdata_a_q;
  assign bus.rdata_b_comp = ~rdata_b_q;
  assign bus.valid_a      = valid_a_q;
  assign bus.valid_b      = valid_b_q;

endmodule
